// File: rtl/iob_ptfloat_mul_pipe_pkg.sv
// rtl/iob_ptfloat_mul_pipe_pkg.sv - rounding modes and shared constants for the ptfloat multiplier
package iob_ptfloat_mul_pipe_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_STICKY    = 2'd1,
    RND_RNE       = 2'd2,
    RND_TRUNC_ALT = 2'd3
  } rnd_mode_e;

  // Headroom bits on the exponent so sum plus normalisation never wraps.
  localparam int EXP_GUARD_W = 2;

  function automatic rnd_mode_e decode_rnd(input logic [1:0] code);
    if (code == RND_TRUNC_ALT) begin
      return RND_TRUNC;
    end
    return rnd_mode_e'(code);
  endfunction

endpackage

// File: rtl/iob_ptfloat_mul_pipe_round.sv
// rtl/iob_ptfloat_mul_pipe_round.sv - guard/sticky/RNE rounding with post-increment renormalisation
module iob_ptfloat_mul_pipe_round
  import iob_ptfloat_mul_pipe_pkg::*;
#(
  parameter int PW    = 48,
  parameter int RES_W = 26,
  parameter int EW    = 10
) (
  input  logic [PW-1:0]    p_i,
  input  logic [EW-1:0]    e_i,
  input  logic [1:0]       rnd_i,
  output logic [RES_W-1:0] man_o,
  output logic [EW-1:0]    exp_o,
  output logic             zero_o
);

  // Two zero bits appended so guard/sticky exist even when RES_W == PW.
  localparam int XW = PW + 2;
  localparam logic [EW-1:0] EXP_ZERO = {3'b111, {(EW-3){1'b0}}};

  logic [XW-1:0]    p_x;
  logic [RES_W-1:0] kept;
  logic             guard;
  logic             sticky;
  logic             inc;
  logic             ovf;
  logic [RES_W:0]   sum;
  logic [RES_W-1:0] man_r;
  rnd_mode_e        mode;

  assign p_x    = {p_i, 2'b00};
  assign kept   = p_x[XW-1 -: RES_W];
  assign guard  = p_x[XW-1-RES_W];
  assign sticky = |p_x[XW-2-RES_W:0];
  assign mode   = decode_rnd(rnd_i);
  assign inc    = (mode == RND_RNE) && guard && (sticky || kept[0]);

  // Extra sign bit catches the 01..1 -> 10..0 wrap on increment.
  assign sum = {kept[RES_W-1], kept} + {{RES_W{1'b0}}, inc};
  assign ovf = sum[RES_W] ^ sum[RES_W-1];

  always_comb begin
    man_r = ovf ? sum[RES_W:1] : sum[RES_W-1:0];
    if (mode == RND_STICKY) begin
      man_r[0] = man_r[0] | guard | sticky;
    end
  end

  assign zero_o = (man_r == '0);
  assign man_o  = man_r;
  assign exp_o  = zero_o ? EXP_ZERO : (e_i + {{(EW-1){1'b0}}, ovf});

endmodule

// File: rtl/iob_ptfloat_mul_pipe.sv
// rtl/iob_ptfloat_mul_pipe.sv - stallable pt-float multiplier with selectable latency and rounding
module iob_ptfloat_mul_pipe
  import iob_ptfloat_mul_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int RES_W = 26,
  parameter int LAT   = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  input  logic                 cke_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           rnd_i,
  input  logic [EXP_W-1:0]     exp_a_i,
  input  logic [MAN_W-1:0]     man_a_i,
  input  logic [EXP_W-1:0]     exp_b_i,
  input  logic [MAN_W-1:0]     man_b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_W+1:0]     exp_o,
  output logic [RES_W-1:0]     man_o,
  output logic                 zero_o
);

  localparam int EW = EXP_W + EXP_GUARD_W;
  localparam int PW = 2 * MAN_W;
  localparam int SW = $clog2(PW) + 1;
  // Stage bus layout: {valid, rnd, exponent, product}.
  localparam int BW = 1 + 2 + EW + PW;

  logic                 en;
  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod;
  logic [EW-1:0]        e_sum;
  logic [BW-1:0]        s1_q;
  logic [BW-1:0]        pre_n;
  logic [BW-1:0]        norm_n;
  logic [BW-1:0]        post_n;

  assign en      = cke_i & (~valid_o | ready_i);
  assign ready_o = en;

  assign a_x   = {{MAN_W{man_a_i[MAN_W-1]}}, man_a_i};
  assign b_x   = {{MAN_W{man_b_i[MAN_W-1]}}, man_b_i};
  assign prod  = a_x * b_x;
  assign e_sum = {{EXP_GUARD_W{exp_a_i[EXP_W-1]}}, exp_a_i}
               + {{EXP_GUARD_W{exp_b_i[EXP_W-1]}}, exp_b_i};

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1_q <= '0;
    end else if (en) begin
      s1_q <= {valid_i, rnd_i, e_sum, prod};
    end
  end

  generate
    if (LAT >= 3) begin : g_mul_reg
      logic [BW-1:0] s2_q;
      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
          s2_q <= '0;
        end else if (en) begin
          s2_q <= s1_q;
        end
      end
      assign pre_n = s2_q;
    end else begin : g_mul_pass
      assign pre_n = s1_q;
    end
  endgenerate

  logic          pre_v;
  logic [1:0]    pre_rnd;
  logic [EW-1:0] pre_e;
  logic [PW-1:0] pre_p;
  logic [PW-1:0] q;
  logic [SW-1:0] sh;
  logic          found;
  logic [EW-1:0] norm_e;
  logic [PW-1:0] norm_p;

  assign pre_v   = pre_n[BW-1];
  assign pre_rnd = pre_n[BW-2 -: 2];
  assign pre_e   = pre_n[PW +: EW];
  assign pre_p   = pre_n[PW-1:0];

  // Product is Q2: a sign change in the top two bits means magnitude >= 1.
  always_comb begin
    q     = pre_p << 1;
    sh    = '0;
    found = 1'b0;
    for (int i = PW - 2; i >= 0; i--) begin
      if (!found && (q[i] != q[PW-1])) begin
        sh    = SW'(PW - 2 - i);
        found = 1'b1;
      end
    end
    if (pre_p[PW-1] ^ pre_p[PW-2]) begin
      norm_p = pre_p;
      norm_e = pre_e + EW'(1);
    end else begin
      norm_p = q << sh;
      norm_e = pre_e - EW'(sh);
    end
  end

  assign norm_n = {pre_v, pre_rnd, norm_e, norm_p};

  generate
    if (LAT >= 4) begin : g_norm_reg
      logic [BW-1:0] s3_q;
      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
          s3_q <= '0;
        end else if (en) begin
          s3_q <= norm_n;
        end
      end
      assign post_n = s3_q;
    end else begin : g_norm_pass
      assign post_n = norm_n;
    end
  endgenerate

  logic [RES_W-1:0] r_man;
  logic [EW-1:0]    r_exp;
  logic             r_zero;

  iob_ptfloat_mul_pipe_round #(
    .PW    (PW),
    .RES_W (RES_W),
    .EW    (EW)
  ) u_round (
    .p_i    (post_n[PW-1:0]),
    .e_i    (post_n[PW +: EW]),
    .rnd_i  (post_n[BW-2 -: 2]),
    .man_o  (r_man),
    .exp_o  (r_exp),
    .zero_o (r_zero)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_o <= 1'b0;
      exp_o   <= '0;
      man_o   <= '0;
      zero_o  <= 1'b0;
    end else if (en) begin
      valid_o <= post_n[BW-1];
      exp_o   <= r_exp;
      man_o   <= r_man;
      zero_o  <= r_zero;
    end
  end

endmodule

// File: tb/tb_iob_ptfloat_mul_pipe.sv
// tb/tb_iob_ptfloat_mul_pipe.sv - scoreboard bench for the ptfloat multiplier (LAT=2 and LAT=4)
module tb_iob_ptfloat_mul_pipe;

  typedef struct {
    logic [7:0] ea, ma, eb, mb;
    logic [1:0] rnd;
    logic [7:0] man;
    logic [9:0] ex;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] man;
    logic [9:0] ex;
    logic       zero;
    int         acc;
    bit         chk_lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       arst_n, cke;
  logic       v_i2, rdy_o2, v_o2, rdy_i2, z_o2;
  logic [1:0] rnd2;
  logic [7:0] ea2, ma2, eb2, mb2, man_o2;
  logic [9:0] ex_o2;
  logic       v_i4, rdy_o4, v_o4, rdy_i4, z_o4;
  logic [1:0] rnd4;
  logic [7:0] ea4, ma4, eb4, mb4, man_o4;
  logic [9:0] ex_o4;

  iob_ptfloat_mul_pipe #(.EXP_W(8), .MAN_W(8), .RES_W(8), .LAT(2)) dut2 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .valid_i(v_i2), .ready_o(rdy_o2),
    .rnd_i(rnd2), .exp_a_i(ea2), .man_a_i(ma2), .exp_b_i(eb2), .man_b_i(mb2),
    .valid_o(v_o2), .ready_i(rdy_i2), .exp_o(ex_o2), .man_o(man_o2), .zero_o(z_o2)
  );

  iob_ptfloat_mul_pipe #(.EXP_W(8), .MAN_W(8), .RES_W(8), .LAT(4)) dut4 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .valid_i(v_i4), .ready_o(rdy_o4),
    .rnd_i(rnd4), .exp_a_i(ea4), .man_a_i(ma4), .exp_b_i(eb4), .man_b_i(mb4),
    .valid_o(v_o4), .ready_i(rdy_i4), .exp_o(ex_o4), .man_o(man_o4), .zero_o(z_o4)
  );

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n4_pop = 0;
  exp_t q2[$];
  exp_t q4[$];
  exp_t m2, m4;
  vec_t v2[15];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual timeout/empty required event", name);
  endtask

  function automatic vec_t mk(input logic [7:0] ea, input logic [7:0] ma, input logic [7:0] eb,
                              input logic [7:0] mb, input logic [1:0] rnd, input logic [7:0] man,
                              input logic [9:0] ex, input logic zero);
    vec_t v;
    v.ea = ea; v.ma = ma; v.eb = eb; v.mb = mb; v.rnd = rnd;
    v.man = man; v.ex = ex; v.zero = zero;
    return v;
  endfunction

  task automatic send(input int which, input vec_t v, input bit chk_lat);
    int   tries;
    exp_t e;
    tries = 0;
    @(posedge clk);
    #1;
    if (which == 2) begin
      v_i2 = 1'b1; rnd2 = v.rnd; ea2 = v.ea; ma2 = v.ma; eb2 = v.eb; mb2 = v.mb;
    end else begin
      v_i4 = 1'b1; rnd4 = v.rnd; ea4 = v.ea; ma4 = v.ma; eb4 = v.eb; mb4 = v.mb;
    end
    @(negedge clk);
    while ((((which == 2) ? rdy_o2 : rdy_o4) !== 1'b1) && tries < 50) begin
      tries++;
      @(negedge clk);
    end
    if (tries >= 50) begin
      fail_now("accept timeout");
    end else begin
      e.man = v.man; e.ex = v.ex; e.zero = v.zero; e.acc = cyc; e.chk_lat = chk_lat;
      if (which == 2) q2.push_back(e);
      else q4.push_back(e);
    end
  endtask

  task automatic idle(input int which);
    @(posedge clk);
    #1;
    if (which == 2) v_i2 = 1'b0;
    else v_i4 = 1'b0;
  endtask

  task automatic drain(input int which);
    int t;
    t = 0;
    while ((((which == 2) ? q2.size() : q4.size()) != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (((which == 2) ? q2.size() : q4.size()) != 0) fail_now("drain timeout");
  endtask

  always @(negedge clk) begin
    if (arst_n && v_o2) begin
      if (q2.size() == 0) begin
        fail_now("dut2 unexpected result");
      end else begin
        m2 = q2.pop_front();
        chk("dut2 man", 32'(man_o2), 32'(m2.man));
        chk("dut2 exp", 32'(ex_o2), 32'(m2.ex));
        chk("dut2 zero", 32'(z_o2), 32'(m2.zero));
        if (m2.chk_lat) chk("dut2 latency", 32'(cyc - m2.acc), 32'd2);
      end
    end
  end

  always @(negedge clk) begin
    if (arst_n && v_o4) begin
      if (q4.size() == 0) begin
        fail_now("dut4 unexpected result");
      end else if (rdy_i4) begin
        m4 = q4.pop_front();
        n4_pop++;
        chk("dut4 man", 32'(man_o4), 32'(m4.man));
        chk("dut4 exp", 32'(ex_o4), 32'(m4.ex));
        chk("dut4 zero", 32'(z_o4), 32'(m4.zero));
      end else begin
        chk("dut4 stall ready_o", 32'(rdy_o4), 32'd0);
        chk("dut4 stall man held", 32'(man_o4), 32'(q4[0].man));
        chk("dut4 stall exp held", 32'(ex_o4), 32'(q4[0].ex));
      end
    end
  end

  initial begin
    arst_n = 1'b0; cke = 1'b1;
    v_i2 = 1'b0; rdy_i2 = 1'b1; rnd2 = '0; ea2 = '0; ma2 = '0; eb2 = '0; mb2 = '0;
    v_i4 = 1'b0; rdy_i4 = 1'b1; rnd4 = '0; ea4 = '0; ma4 = '0; eb4 = '0; mb4 = '0;

    v2[0]  = mk(8'h00, 8'h40, 8'h00, 8'h40, 2'd0, 8'h40, 10'h3FF, 1'b0);
    v2[1]  = mk(8'h00, 8'h80, 8'h00, 8'h80, 2'd0, 8'h40, 10'h001, 1'b0);
    v2[2]  = mk(8'h00, 8'h7F, 8'h00, 8'h7F, 2'd0, 8'h7E, 10'h000, 1'b0);
    v2[3]  = mk(8'h00, 8'h7F, 8'h00, 8'h7F, 2'd1, 8'h7F, 10'h000, 1'b0);
    v2[4]  = mk(8'h00, 8'h7F, 8'h00, 8'h7F, 2'd2, 8'h7E, 10'h000, 1'b0);
    v2[5]  = mk(8'h03, 8'h00, 8'hFE, 8'h55, 2'd2, 8'h00, 10'h380, 1'b1);
    v2[6]  = mk(8'h05, 8'h40, 8'hFD, 8'h80, 2'd0, 8'h80, 10'h001, 1'b0);
    v2[7]  = mk(8'h00, 8'h60, 8'h00, 8'h55, 2'd2, 8'h40, 10'h000, 1'b0);
    v2[8]  = mk(8'h00, 8'h60, 8'h00, 8'h55, 2'd0, 8'h7F, 10'h3FF, 1'b0);
    v2[9]  = mk(8'h00, 8'h58, 8'h00, 8'h5C, 2'd2, 8'h7E, 10'h3FF, 1'b0);
    v2[10] = mk(8'h00, 8'h81, 8'h00, 8'h7F, 2'd2, 8'h82, 10'h000, 1'b0);
    v2[11] = mk(8'h00, 8'h81, 8'h00, 8'h7F, 2'd3, 8'h81, 10'h000, 1'b0);
    v2[12] = mk(8'h7F, 8'h80, 8'h7F, 8'h80, 2'd0, 8'h40, 10'h0FF, 1'b0);
    v2[13] = mk(8'h80, 8'h40, 8'h80, 8'h40, 2'd0, 8'h40, 10'h2FF, 1'b0);
    v2[14] = mk(8'h10, 8'h9A, 8'h20, 8'h00, 2'd1, 8'h00, 10'h380, 1'b1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dut2 valid_o", 32'(v_o2), 32'd0);
    chk("reset dut2 man_o", 32'(man_o2), 32'd0);
    chk("reset dut2 exp_o", 32'(ex_o2), 32'd0);
    chk("reset dut2 zero_o", 32'(z_o2), 32'd0);
    chk("reset dut4 valid_o", 32'(v_o4), 32'd0);
    chk("reset dut4 man_o", 32'(man_o4), 32'd0);
    chk("reset dut4 exp_o", 32'(ex_o4), 32'd0);
    chk("reset dut4 zero_o", 32'(z_o4), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;

    for (int i = 0; i < 15; i++) send(2, v2[i], 1'b1);
    idle(2);
    drain(2);

    fork
      begin
        for (int k = 0; k < 8; k++) begin
          if (k % 2 == 0) send(4, mk(8'(k), 8'h40, 8'h01, 8'h40, 2'd0, 8'h40, 10'(k), 1'b0), 1'b0);
          else send(4, mk(8'(k), 8'h80, 8'h01, 8'h80, 2'd0, 8'h40, 10'(k + 2), 1'b0), 1'b0);
        end
        idle(4);
      end
      begin
        repeat (6) @(posedge clk);
        #1 rdy_i4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy_i4 = 1'b1;
      end
    join
    drain(4);
    chk("dut4 results retired", 32'(n4_pop), 32'd8);

    send(2, v2[0], 1'b1);
    send(2, v2[1], 1'b1);
    idle(2);
    #1 arst_n = 1'b0;
    q2.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in-reset dut2 valid_o", 32'(v_o2), 32'd0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("post-release dut2 valid_o", 32'(v_o2), 32'd0);
    send(2, v2[2], 1'b1);
    idle(2);
    drain(2);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
